// File: rtl/ipmxb_qsgmii_hsst_rx_rst_fsm_v1_0_pkg.sv
// Shared definitions for the QSGMII HSST receive-lane reset sequencer.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package ipmxb_qsgmii_hsst_rx_rst_fsm_v1_0_pkg;

    localparam logic [2:0] ST_WAIT_PLL   = 3'd0;
    localparam logic [2:0] ST_PMA_RST    = 3'd1;
    localparam logic [2:0] ST_WAIT_CDR   = 3'd2;
    localparam logic [2:0] ST_PCS_RST    = 3'd3;
    localparam logic [2:0] ST_WAIT_ALIGN = 3'd4;
    localparam logic [2:0] ST_DONE       = 3'd5;

    localparam int                  RETRY_W   = 8;
    localparam logic [RETRY_W-1:0]  RETRY_MAX = 8'hFF;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ipmxb_qsgmii_hsst_rst_tmo_v1_0.sv
// Clearable, enable-gated wait-budget counter with terminal-count flag.
// Latency: tc is combinational from the registered count; count updates each clk.
// Backpressure: none; clr has priority over en.
module ipmxb_qsgmii_hsst_rst_tmo_v1_0 #(
    parameter int P_TIMEOUT = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int TW = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TW'(1);
        end
    end

    assign tc = en && (cnt == TW'(P_TIMEOUT - 1));

endmodule

// File: rtl/ipmxb_qsgmii_hsst_rx_rst_fsm_v1_0.sv
// Receive-lane reset sequencer: orders power-down, PMA reset, PCS reset and done.
// Latency: a qualifying input sampled at edge N updates state and outputs after edge N.
// Backpressure: none; loss events preempt timeouts, which preempt normal progress.
module ipmxb_qsgmii_hsst_rx_rst_fsm_v1_0
    import ipmxb_qsgmii_hsst_rx_rst_fsm_v1_0_pkg::*;
#(
    parameter int P_PMA_RST_CYC = 16,
    parameter int P_LOCK_DEB    = 1024,
    parameter int P_PCS_RST_CYC = 16,
    parameter int P_TIMEOUT     = 65536
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_lock_sync,
    input  logic               sigdet_sync,
    input  logic               cdr_lock_sync,
    input  logic               word_align_sync,
    output logic               rx_lane_pd,
    output logic               rx_pma_rst,
    output logic               rx_pcs_rst,
    output logic               rx_rst_done,
    output logic [RETRY_W-1:0] rx_retry_cnt,
    output logic [2:0]         rx_fsm_st
);

    localparam int CNT_MAX = max3(P_PMA_RST_CYC, P_LOCK_DEB, P_PCS_RST_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX);

    logic [2:0]       st;
    logic [2:0]       nxt;
    logic [CNT_W-1:0] cnt;
    logic             restart;
    logic             tmo_hit;
    logic             ent;
    logic             in_wait;
    logic             tc;
    logic             pd_d, pma_d, pcs_d, done_d;

    assign in_wait = (st == ST_WAIT_CDR) || (st == ST_WAIT_ALIGN);
    // restart also covers re-entry of the current state (sigdet loss in PMA reset)
    assign ent     = restart || (nxt != st);

    ipmxb_qsgmii_hsst_rst_tmo_v1_0 #(
        .P_TIMEOUT (P_TIMEOUT)
    ) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ent),
        .en    (in_wait),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= ST_WAIT_PLL;
        end else begin
            st <= nxt;
        end
    end

    always_comb begin
        nxt     = st;
        restart = 1'b0;
        tmo_hit = 1'b0;
        if (st == ST_WAIT_PLL) begin
            if (pll_lock_sync && sigdet_sync) nxt = ST_PMA_RST;
        end else if (!pll_lock_sync) begin
            nxt     = ST_WAIT_PLL;
            restart = 1'b1;
        end else if (!sigdet_sync) begin
            nxt     = ST_PMA_RST;
            restart = 1'b1;
        end else if (!cdr_lock_sync && (st == ST_PCS_RST || st == ST_WAIT_ALIGN || st == ST_DONE)) begin
            nxt     = ST_PMA_RST;
            restart = 1'b1;
        end else if (!word_align_sync && (st == ST_DONE)) begin
            nxt     = ST_PCS_RST;
            restart = 1'b1;
        end else if (tc) begin
            nxt     = ST_PMA_RST;
            restart = 1'b1;
            tmo_hit = 1'b1;
        end else begin
            case (st)
                ST_PMA_RST:    if (cnt == CNT_W'(P_PMA_RST_CYC - 1)) nxt = ST_WAIT_CDR;
                ST_WAIT_CDR:   if (cdr_lock_sync && cnt == CNT_W'(P_LOCK_DEB - 1)) nxt = ST_PCS_RST;
                ST_PCS_RST:    if (cnt == CNT_W'(P_PCS_RST_CYC - 1)) nxt = ST_WAIT_ALIGN;
                ST_WAIT_ALIGN: if (word_align_sync) nxt = ST_DONE;
                ST_DONE:       nxt = ST_DONE;
                default:       nxt = ST_WAIT_PLL;
            endcase
        end
    end

    always_comb begin
        pd_d   = 1'b0;
        pma_d  = 1'b0;
        pcs_d  = 1'b0;
        done_d = 1'b0;
        case (nxt)
            ST_WAIT_PLL:   begin pd_d = 1'b1; pma_d = 1'b1; pcs_d = 1'b1; end
            ST_PMA_RST:    begin pma_d = 1'b1; pcs_d = 1'b1; end
            ST_WAIT_CDR:   pcs_d = 1'b1;
            ST_PCS_RST:    pcs_d = 1'b1;
            ST_WAIT_ALIGN: ;
            ST_DONE:       done_d = 1'b1;
            default:       begin pd_d = 1'b1; pma_d = 1'b1; pcs_d = 1'b1; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_lane_pd  <= 1'b1;
            rx_pma_rst  <= 1'b1;
            rx_pcs_rst  <= 1'b1;
            rx_rst_done <= 1'b0;
        end else begin
            rx_lane_pd  <= pd_d;
            rx_pma_rst  <= pma_d;
            rx_pcs_rst  <= pcs_d;
            rx_rst_done <= done_d;
        end
    end

    // One counter serves both dwell timing and CDR-lock debounce
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ent) begin
            cnt <= '0;
        end else begin
            case (st)
                ST_PMA_RST:  cnt <= cnt + CNT_W'(1);
                ST_PCS_RST:  cnt <= cnt + CNT_W'(1);
                ST_WAIT_CDR: cnt <= cdr_lock_sync ? cnt + CNT_W'(1) : '0;
                default:     cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_retry_cnt <= '0;
        end else if (tmo_hit && rx_retry_cnt != RETRY_MAX) begin
            rx_retry_cnt <= rx_retry_cnt + RETRY_W'(1);
        end
    end

    assign rx_fsm_st = st;

endmodule

// File: doc/ipmxb_qsgmii_hsst_rx_rst_fsm_v1_0.md
# ipmxb_qsgmii_hsst_rx_rst_fsm_v1_0

Receive-lane reset sequencer for the QSGMII HSST reset block. It sits directly downstream of the two-flop single-bit synchronizers, consuming the synchronized PLL-lock, signal-detect, CDR-lock and word-align status bits. It drives lane power-down, PMA reset and PCS reset in the required order, and asserts `rx_rst_done` once the lane is aligned. Timeouts and loss-of-status events restart the sequence from the appropriate point.

## Interface
Parameters:
- `P_PMA_RST_CYC`, 16: cycles the PMA reset is held after power-up release (min 2).
- `P_LOCK_DEB`, 1024: consecutive cycles `cdr_lock_sync` must stay high before the lock is accepted (min 2).
- `P_PCS_RST_CYC`, 16: cycles the PCS reset is held after CDR lock is accepted (min 2).
- `P_TIMEOUT`, 65536: cycle budget for the CDR-lock and word-align waits (min 4).

Ports:
- `clk`, in, 1: single clock for the whole block.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `pll_lock_sync`, in, 1: PLL lock, already synchronized to `clk`.
- `sigdet_sync`, in, 1: receiver signal detect, already synchronized.
- `cdr_lock_sync`, in, 1: CDR lock, already synchronized.
- `word_align_sync`, in, 1: PCS word alignment achieved, already synchronized.
- `rx_lane_pd`, out, 1: lane power-down, active high.
- `rx_pma_rst`, out, 1: PMA reset, active high.
- `rx_pcs_rst`, out, 1: PCS reset, active high.
- `rx_rst_done`, out, 1: lane is up and aligned.
- `rx_retry_cnt`, out, 8: saturating count of timeout restarts.
- `rx_fsm_st`, out, 3: current state, for debug.

## Operation
States, with outputs given as pd/pma/pcs/done:
- ST_WAIT_PLL (0), 1/1/1/0: go to ST_PMA_RST when `pll_lock_sync & sigdet_sync`.
- ST_PMA_RST (1), 0/1/1/0: held for `P_PMA_RST_CYC` cycles, then go to ST_WAIT_CDR.
- ST_WAIT_CDR (2), 0/0/1/0:
  - The debounce counter increments while `cdr_lock_sync`=1 and clears when it is 0.
  - When the count reaches `P_LOCK_DEB-1`, go to ST_PCS_RST.
- ST_PCS_RST (3), 0/0/1/0: held for `P_PCS_RST_CYC` cycles, then go to ST_WAIT_ALIGN.
- ST_WAIT_ALIGN (4), 0/0/0/0: go to ST_DONE when `word_align_sync`=1.
- ST_DONE (5), 0/0/0/1: steady state.

Loss events are checked in every state except ST_WAIT_PLL. Priority, highest first:
1. `pll_lock_sync`=0 goes to ST_WAIT_PLL.
2. `sigdet_sync`=0 goes to ST_PMA_RST.
3. `cdr_lock_sync`=0 in ST_PCS_RST, ST_WAIT_ALIGN or ST_DONE goes to ST_PMA_RST.
4. `word_align_sync`=0 in ST_DONE goes to ST_PCS_RST.

Timeout:
- A separate counter counts cycles spent in ST_WAIT_CDR and ST_WAIT_ALIGN. It is cleared on entry to either state.
- When it reaches `P_TIMEOUT-1`, the FSM goes to ST_PMA_RST and `rx_retry_cnt` increments, saturating at 255.
- A loss event in the same cycle takes priority and does not increment `rx_retry_cnt`.

Counter rules:
- The dwell/debounce counter clears on every state entry.
- Counter widths are `$clog2` of the largest parameter they compare against.
- No counter wraps; the compare forces a state exit first.

## Timing
- Reset values: `rx_fsm_st`=0, `rx_lane_pd`=1, `rx_pma_rst`=1, `rx_pcs_rst`=1, `rx_rst_done`=0, `rx_retry_cnt`=0.
- All outputs are registered and decoded from the next state, so they change on the same edge as `rx_fsm_st`.
- Inputs are used with no further synchronizing; the upstream synchronizers supply them.
- A qualifying input sampled at edge N gives the new state and outputs after edge N.
- Dwell states occupy exactly their parameter's number of cycles.
- `rst_n` assertion mid-sequence forces reset values asynchronously, including `rx_retry_cnt`. After release, sequencing restarts from ST_WAIT_PLL.

## Structure
- Shared package holds:
  - state encodings ST_WAIT_PLL to ST_DONE, as 3-bit localparams;
  - the `rx_retry_cnt` width (8) and its saturation value.
- One natural sub-module, `ipmxb_qsgmii_hsst_rst_tmo_v1_0`: a clearable, enable-gated timeout counter with parameter `P_TIMEOUT` and a terminal-count output.
- The FSM, dwell/debounce counter and output decode stay in this module.

## Test plan
Parameters for all scenarios: `P_PMA_RST_CYC`=4, `P_LOCK_DEB`=8, `P_PCS_RST_CYC`=4, `P_TIMEOUT`=64.
- **Normal bring-up.** Raise `pll_lock_sync` and `sigdet_sync` at edge 10, then hold `cdr_lock_sync` and `word_align_sync` high. Required: pd falls after edge 11; pma falls 4 cycles later; pcs falls 8+4 cycles after that; `rx_rst_done`=1 one cycle after ST_WAIT_ALIGN is entered.
- **Debounce.** Glitch `cdr_lock_sync` low for 1 cycle after 6 high cycles. Required: stay in ST_WAIT_CDR; exit 8 cycles after the glitch ends.
- **Timeout.** Hold `cdr_lock_sync`=0. Required: after 64 cycles, return to ST_PMA_RST with pma=1 and `rx_retry_cnt`=1. Repeat 300 times and check `rx_retry_cnt` saturates at 255.
- **Align loss in ST_DONE.** Drop `word_align_sync` for 1 cycle. Required: `rx_rst_done`=0 and pcs=1 next cycle, then ST_PCS_RST for 4 cycles, then recovery.
- **Simultaneous losses.** Drop `pll_lock_sync` and `cdr_lock_sync` in the same cycle while in ST_DONE. Required: ST_WAIT_PLL with pd/pma/pcs=1/1/1 and `rx_retry_cnt` unchanged.
- **Reset mid-operation.** Assert `rst_n` low in ST_PCS_RST. Required: all outputs take their reset values immediately, with no clock edge needed.
